ps2_frame_rx: RTL and testbench



---
 rtl/ps2_frame_rx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter, 11-bit
// frame deframer with parity/stop checks, and a first-word-fall-through scan-code FIFO.
module ps2_frame_rx #(
  parameter int unsigned AW   = 3,
  parameter int unsigned FILT = 8,
  parameter int unsigned TMO  = 100000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  output logic [7:0]    code_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [AW:0]   count_o,
  output logic          perr_o,
  output logic          ferr_o,
  output logic          ovf_o
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned FW    = $clog2(FILT + 1);
  localparam int unsigned TW    = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_e;

  logic [1:0]    clk_s_q, data_s_q;
  logic          filt_q, filt_d;
  logic          prev_q, prev_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_c;
  logic          sdata_c;

  state_e        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic          push_c;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [7:0]    code_q, code_d;
  logic          pop_c, full_c, wr_en_c;

  // Clock filter: filtered clk follows synced clk only after FILT differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    prev_d = filt_q;
    if (clk_s_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILT - 1)) filt_d = clk_s_q[1];
      else                         fcnt_d = fcnt_q + FW'(1);
    end
  end

  assign fall_c  = prev_q & ~filt_q;
  assign sdata_c = data_s_q[1];

  // Deframer FSM with frame timeout
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmo_d   = tmo_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    push_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall_c && !sdata_c) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
      end
      DATA: if (fall_c) begin
        shift_d = {sdata_c, shift_q[7:1]};
        bcnt_d  = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = PAR;
      end
      PAR: if (fall_c) begin
        par_d   = sdata_c;
        state_d = STOP;
      end
      STOP: if (fall_c) begin
        state_d = IDLE;
        if (!sdata_c)                 ferr_d = 1'b1;
        else if (~^{shift_q, par_q})  perr_d = 1'b1;
        else                          push_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      if (fall_c) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TMO - 1)) begin
        state_d = IDLE;
        ferr_d  = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // FIFO control; code_d precomputes the head that will be visible next cycle
  always_comb begin
    pop_c   = valid_q & ready_i;
    full_c  = (cnt_q == (AW + 1)'(DEPTH));
    wr_en_c = push_c & (~full_c | pop_c);
    ovf_d   = push_c & full_c & ~pop_c;
    wr_d    = wr_en_c ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_c   ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q;
    if (wr_en_c && !pop_c)      cnt_d = cnt_q + (AW + 1)'(1);
    else if (!wr_en_c && pop_c) cnt_d = cnt_q - (AW + 1)'(1);
    valid_d = (cnt_d != '0);
    code_d  = code_q;
    if (cnt_d != '0) begin
      if (wr_en_c && (wr_q == rd_d)) code_d = shift_q;
      else                           code_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      clk_s_q  <= 2'b11;
      data_s_q <= 2'b11;
      filt_q   <= 1'b1;
      prev_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      bcnt_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      clk_s_q  <= {clk_s_q[0], ps2_clk};
      data_s_q <= {data_s_q[0], ps2_data};
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
    end
  end

  // Storage array carries no reset; occupancy and pointers define its validity
  always_ff @(posedge wb_clk_i) begin
    if (wr_en_c && !wb_rst_i) mem_q[wr_q] <= shift_q;
  end

  assign code_o  = code_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;
  assign perr_o  = perr_q;
  assign ferr_o  = ferr_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: bit-level PS/2 device model with hand-picked frames.
module tb_ps2_frame_rx;

  localparam int unsigned AW   = 3;
  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 2000;
  localparam int          H    = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          ready = 1'b0;
  logic [7:0]    code_o;
  logic          valid_o;
  logic [AW:0]   count_o;
  logic          perr_o, ferr_o, ovf_o;

  int n_checks = 0, n_err = 0;
  int cyc = 0, perr_n = 0, ferr_n = 0, ovf_n = 0, multi_n = 0;
  int fall_cyc = 0, pop_at = -1;
  logic v_pre = 1'b0, v_post = 1'b0;
  bit watch8 = 1'b0, not8 = 1'b0;
  int p0, f0, o0, delay;
  bit seen;

  ps2_frame_rx #(.AW(AW), .FILT(FILT), .TMO(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code_o   (code_o),
    .valid_o  (valid_o),
    .ready_i  (ready),
    .count_o  (count_o),
    .perr_o   (perr_o),
    .ferr_o   (ferr_o),
    .ovf_o    (ovf_o)
  );

  always #10 clk = ~clk;

  // Cycle counter and error-pulse tallies
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (perr_o) perr_n <= perr_n + 1;
    if (ferr_o) ferr_n <= ferr_n + 1;
    if (ovf_o)  ovf_n  <= ovf_n + 1;
    if ((32'(perr_o) + 32'(ferr_o) + 32'(ovf_o)) > 32'd1) multi_n <= multi_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // One PS/2 bit: data set while clk high, then a low phase of lo cycles
  task automatic send_bit(input logic b, input int lo, input bit glitch);
    @(negedge clk) ps2_data = b;
    repeat (H / 2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FILT - 1) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (H / 2) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    for (int i = 1; i <= lo; i++) begin
      @(negedge clk);
      ready = (i == pop_at);
      if (i == FILT + 2) v_pre  = valid_o;
      if (i == FILT + 3) v_post = valid_o;
      if (watch8 && (count_o != 4'd8)) not8 = 1'b1;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int lo, input int gbit, input bit popstop);
    logic [10:0] fr;
    fr = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      pop_at = (popstop && i == 10) ? int'(FILT + 2) : -1;
      send_bit(fr[i], lo, i == gbit);
    end
    pop_at = -1;
    @(negedge clk) ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_code",  32'(code_o),  32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_errs",  32'({perr_o, ferr_o, ovf_o}), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single good frame, exact push latency, then pop
    p0 = perr_n; f0 = ferr_n;
    send_frame(8'h1C, 1'b0, 1'b1, H, -1, 1'b0);
    check("lat_pre",  32'(v_pre),  32'h0);
    check("lat_post", 32'(v_post), 32'h1);
    check("f1_valid", 32'(valid_o), 32'h1);
    check("f1_code",  32'(code_o),  32'h1C);
    check("f1_count", 32'(count_o), 32'h1);
    check("f1_noerr", 32'((perr_n - p0) + (ferr_n - f0)), 32'h0);
    pop_one();
    check("f1_pop_valid", 32'(valid_o), 32'h0);
    check("f1_pop_count", 32'(count_o), 32'h0);

    // Back to back, popped in order
    send_frame(8'hF0, 1'b1, 1'b1, H, -1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, H, -1, 1'b0);
    check("b2b_count", 32'(count_o), 32'h2);
    check("b2b_head0", 32'(code_o),  32'hF0);
    pop_one();
    check("b2b_head1", 32'(code_o),  32'h1C);
    check("b2b_cnt1",  32'(count_o), 32'h1);
    pop_one();
    check("b2b_cnt0",  32'(count_o), 32'h0);

    // Parity error, then stop error
    p0 = perr_n; f0 = ferr_n;
    send_frame(8'h1C, 1'b1, 1'b1, H, -1, 1'b0);
    check("perr_pulse", 32'(perr_n - p0), 32'h1);
    check("perr_noferr", 32'(ferr_n - f0), 32'h0);
    check("perr_count", 32'(count_o), 32'h0);
    p0 = perr_n; f0 = ferr_n;
    send_frame(8'h1C, 1'b0, 1'b0, H, -1, 1'b0);
    check("ferr_pulse", 32'(ferr_n - f0), 32'h1);
    check("ferr_noperr", 32'(perr_n - p0), 32'h0);
    check("ferr_count", 32'(count_o), 32'h0);

    // Sub-threshold glitches in IDLE (data low) and mid-frame
    @(negedge clk) ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (FILT - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    p0 = perr_n; f0 = ferr_n;
    send_frame(8'h1C, 1'b0, 1'b1, H, 3, 1'b0);
    check("glitch_code",  32'(code_o),  32'h1C);
    check("glitch_count", 32'(count_o), 32'h1);
    check("glitch_noerr", 32'((perr_n - p0) + (ferr_n - f0)), 32'h0);
    pop_one();

    // Low phases of exactly FILT cycles still register as edges
    send_frame(8'h29, 1'b0, 1'b1, FILT, -1, 1'b0);
    check("short_code",  32'(code_o),  32'h29);
    check("short_count", 32'(count_o), 32'h1);
    pop_one();

    // Timeout after four data bits
    f0 = ferr_n;
    send_bit(1'b0, H, 1'b0);
    send_bit(1'b0, H, 1'b0);
    send_bit(1'b0, H, 1'b0);
    send_bit(1'b1, H, 1'b0);
    send_bit(1'b1, H, 1'b0);
    @(negedge clk) ps2_data = 1'b1;
    seen = 1'b0;
    delay = 0;
    for (int i = 0; i < int'(TMO) + 200 && !seen; i++) begin
      @(negedge clk);
      if (ferr_o) begin
        seen  = 1'b1;
        delay = cyc - fall_cyc;
      end
    end
    check("tmo_seen",  32'(seen), 32'h1);
    check("tmo_delay", 32'(delay), 32'(TMO + FILT + 3));
    repeat (5) @(negedge clk);
    check("tmo_pulses", 32'(ferr_n - f0), 32'h1);
    check("tmo_count",  32'(count_o), 32'h0);
    send_frame(8'h29, 1'b0, 1'b1, H, -1, 1'b0);
    check("tmo_next_code",  32'(code_o),  32'h29);
    check("tmo_next_count", 32'(count_o), 32'h1);
    pop_one();

    // Fill, overflow, push+pop while full
    for (int i = 0; i < 8; i++)
      send_frame(8'h30 + 8'(i), odd_par(8'h30 + 8'(i)), 1'b1, H, -1, 1'b0);
    check("full_count", 32'(count_o), 32'h8);
    check("full_head",  32'(code_o),  32'h30);
    o0 = ovf_n;
    send_frame(8'h55, odd_par(8'h55), 1'b1, H, -1, 1'b0);
    check("ovf_pulse", 32'(ovf_n - o0), 32'h1);
    check("ovf_count", 32'(count_o), 32'h8);
    check("ovf_head",  32'(code_o),  32'h30);
    o0 = ovf_n;
    watch8 = 1'b1;
    send_frame(8'h66, odd_par(8'h66), 1'b1, H, -1, 1'b1);
    watch8 = 1'b0;
    check("pp_noovf", 32'(ovf_n - o0), 32'h0);
    check("pp_count", 32'(count_o), 32'h8);
    check("pp_stay8", 32'(not8), 32'h0);
    check("pp_head",  32'(code_o),  32'h31);

    // Reset mid-frame with data buffered
    send_bit(1'b0, H, 1'b0);
    send_bit(1'b1, H, 1'b0);
    send_bit(1'b0, H, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mrst_count", 32'(count_o), 32'h0);
    check("mrst_valid", 32'(valid_o), 32'h0);
    check("mrst_code",  32'(code_o),  32'h0);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1, H, -1, 1'b0);
    check("post_rst_code",  32'(code_o),  32'h1C);
    check("post_rst_count", 32'(count_o), 32'h1);

    check("err_exclusive", 32'(multi_n), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
